// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX->MEM pipeline register sitting directly downstream of the ALU.
//
//   What it does:
//   - Captures the ALU result, flags and instruction control on accept.
//   - Resolves the conditional branch from the zero/great flags.
//   - Raises the overflow trap for trapping add/sub.
//   - Decouples EX from MEM with a 2-entry skid buffer (MAIN + SKID) on a
//     valid/ready handshake.
//
//   Ports:
//     clk, rst_n        clock; asynchronous active-low reset
//     flush             synchronous pipeline kill (clears both slots)
//     in_valid/in_ready EX-side handshake (in_ready is a register output)
//     alu_out, alu_zero, alu_great, alu_overflow, ovf_trap_en
//                       ALU result, flags and trap enable
//     br_type, br_target
//                       branch condition code and branch target
//     pc, rd, reg_wr, mem_rd, mem_wr, st_data
//                       instruction payload and control
//     out_valid/out_ready
//                       MEM-side handshake
//     out_*             registered payload of the MAIN slot
//     redirect_valid/redirect_pc
//                       one-cycle pulse for a taken branch
//     exc_ovf/exc_pc    one-cycle pulse for an overflow trap
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_great,
    input  logic              alu_overflow,
    input  logic              ovf_trap_en,
    input  logic [2:0]        br_type,
    input  logic [PC_W-1:0]   br_target,
    input  logic [PC_W-1:0]   pc,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_wr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] st_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_st_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_wr,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              exc_ovf,
    output logic [PC_W-1:0]   exc_pc
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GT   = 3'd3,
        BR_LE   = 3'd4
    } br_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st_data;
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
    } slot_t;

    slot_t main_q, skid_q, in_slot;
    logic  main_valid, skid_valid;
    logic  accept, drain, trap, taken;

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = main_valid & out_ready;
    assign trap   = alu_overflow & ovf_trap_en;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken = 1'b0;
        unique case (br_e'(br_type))
            BR_EQ:   taken = alu_zero;
            BR_NE:   taken = ~alu_zero;
            BR_GT:   taken = alu_great;
            BR_LE:   taken = ~alu_great;
            default: taken = 1'b0;
        endcase
    end

    // A trapping instruction still flows down the pipe, but it must not
    // write anything architecturally visible.
    always_comb begin
        in_slot.alu     = alu_out;
        in_slot.st_data = st_data;
        in_slot.pc      = pc;
        in_slot.rd      = rd;
        in_slot.reg_wr  = reg_wr & ~trap;
        in_slot.mem_rd  = mem_rd & ~trap;
        in_slot.mem_wr  = mem_wr & ~trap;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order. The
    // payload registers are reset too, so the outputs are defined out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid     <= 1'b0;
            skid_valid     <= 1'b0;
            main_q         <= '0;
            skid_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exc_ovf        <= 1'b0;
            exc_pc         <= '0;
        end else begin
            // accept is already gated by flush, so a flush clears both pulses.
            redirect_valid <= accept & taken & ~trap;
            exc_ovf        <= accept & trap;
            if (accept & taken & ~trap) redirect_pc <= br_target;
            if (accept & trap)          exc_pc      <= pc;

            if (flush) begin
                // Kill both slots; the payload registers keep their contents.
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (accept) begin
                // When SKID is full, in_ready is low, so accept and SKID full
                // are never true together.
                if (!main_valid || drain) begin
                    main_q     <= in_slot;
                    main_valid <= 1'b1;
                end else begin
                    skid_q     <= in_slot;
                    skid_valid <= 1'b1;
                end
            end else if (drain) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= 1'b0;
                end
            end
        end
    end

    // skid_valid is the registered "SKID full" state, so in_ready comes
    // straight from a flop and is high immediately after reset.
    assign in_ready    = ~skid_valid;
    assign out_valid   = main_valid;
    assign out_alu     = main_q.alu;
    assign out_st_data = main_q.st_data;
    assign out_pc      = main_q.pc;
    assign out_rd      = main_q.rd;
    assign out_reg_wr  = main_q.reg_wr;
    assign out_mem_rd  = main_q.mem_rd;
    assign out_mem_wr  = main_q.mem_wr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed self-checking bench for ex_mem_stage. Inputs change 2 ns after
//   the rising edge, and outputs are sampled at that same point, away from
//   the active edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_great;
    logic        alu_overflow;
    logic        ovf_trap_en;
    logic [2:0]  br_type;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] st_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic [31:0] out_st_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_wr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_ovf;
    logic [31:0] exc_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .alu_great     (alu_great),
        .alu_overflow  (alu_overflow),
        .ovf_trap_en   (ovf_trap_en),
        .br_type       (br_type),
        .br_target     (br_target),
        .pc            (pc),
        .rd            (rd),
        .reg_wr        (reg_wr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .st_data       (st_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu       (out_alu),
        .out_st_data   (out_st_data),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_wr    (out_reg_wr),
        .out_mem_rd    (out_mem_rd),
        .out_mem_wr    (out_mem_wr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_ovf       (exc_ovf),
        .exc_pc        (exc_pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction with neutral control and flags.
    task automatic drive(input logic [31:0] a);
        in_valid     = 1'b1;
        alu_out      = a;
        alu_zero     = 1'b0;
        alu_great    = 1'b0;
        alu_overflow = 1'b0;
        ovf_trap_en  = 1'b0;
        br_type      = 3'd0;
        br_target    = 32'h0;
        pc           = 32'h0;
        rd           = 5'd1;
        reg_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        st_data      = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(32'h0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_redirect", redirect_valid, 0);
        check("rst_exc", exc_ovf, 0);
        check("rst_out_alu", out_alu, 0);

        // 1: streaming with out_ready=1
        drive(32'd1);
        tick();
        check("s1_valid", out_valid, 1);
        check("s1_alu", out_alu, 1);
        drive(32'd2);
        tick();
        check("s2_alu", out_alu, 2);
        check("s2_ready", in_ready, 1);
        drive(32'd3);
        tick();
        check("s3_alu", out_alu, 3);
        check("s3_ready", in_ready, 1);
        in_valid = 1'b0;
        tick();
        check("s_drained", out_valid, 0);

        // 2: backpressure fills both slots, release drains in order
        out_ready = 1'b0;
        drive(32'hA);
        tick();
        check("bp_a_alu", out_alu, 32'hA);
        check("bp_a_ready", in_ready, 1);
        drive(32'hB);
        tick();
        check("bp_b_ready", in_ready, 0);
        check("bp_b_hold", out_alu, 32'hA);
        drive(32'hC);
        tick();
        check("bp_c_hold_alu", out_alu, 32'hA);
        check("bp_c_hold_vld", out_valid, 1);
        check("bp_c_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("bp_rel_b", out_alu, 32'hB);
        check("bp_rel_ready", in_ready, 1);
        tick();
        check("bp_rel_c", out_alu, 32'hC);
        check("bp_rel_c_vld", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // 3: branch resolution
        drive(32'h0);
        br_type   = 3'd1;
        alu_zero  = 1'b1;
        br_target = 32'h400;
        tick();
        check("br_eq_pulse", redirect_valid, 1);
        check("br_eq_pc", redirect_pc, 32'h400);
        in_valid = 1'b0;
        tick();
        check("br_eq_one_cycle", redirect_valid, 0);
        drive(32'h0);
        br_type   = 3'd2;
        alu_zero  = 1'b1;
        br_target = 32'h800;
        tick();
        check("br_ne_none", redirect_valid, 0);
        drive(32'h0);
        br_type   = 3'd4;
        alu_great = 1'b0;
        br_target = 32'h900;
        tick();
        check("br_le_pulse", redirect_valid, 1);
        check("br_le_pc", redirect_pc, 32'h900);
        drive(32'h0);
        br_type   = 3'd7;
        alu_zero  = 1'b1;
        alu_great = 1'b1;
        tick();
        check("br_t7_none", redirect_valid, 0);

        // Overflow without trap enable: control passes through, no trap
        drive(32'h5);
        alu_overflow = 1'b1;
        reg_wr       = 1'b1;
        tick();
        check("nt_exc", exc_ovf, 0);
        check("nt_reg_wr", out_reg_wr, 1);

        // 4: overflow trap suppresses control and redirect
        drive(32'h6);
        alu_overflow = 1'b1;
        ovf_trap_en  = 1'b1;
        pc           = 32'h100;
        reg_wr       = 1'b1;
        mem_wr       = 1'b1;
        br_type      = 3'd1;
        alu_zero     = 1'b1;
        br_target    = 32'h444;
        tick();
        check("tr_exc", exc_ovf, 1);
        check("tr_exc_pc", exc_pc, 32'h100);
        check("tr_reg_wr", out_reg_wr, 0);
        check("tr_mem_wr", out_mem_wr, 0);
        check("tr_no_redir", redirect_valid, 0);
        check("tr_valid", out_valid, 1);
        check("tr_alu", out_alu, 32'h6);
        in_valid = 1'b0;
        tick();
        check("tr_one_cycle", exc_ovf, 0);
        tick();

        // 5: flush with both slots full and a trapping, taken-branch input
        out_ready = 1'b0;
        drive(32'h11);
        tick();
        drive(32'h22);
        tick();
        check("fl_full", in_ready, 0);
        drive(32'h33);
        flush        = 1'b1;
        br_type      = 3'd1;
        alu_zero     = 1'b1;
        alu_overflow = 1'b1;
        ovf_trap_en  = 1'b1;
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_redir", redirect_valid, 0);
        check("fl_exc", exc_ovf, 0);
        // Flush with room: the input is still blocked
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_nothing", out_valid, 0);

        // 6: asynchronous reset mid-stall
        out_ready = 1'b0;
        drive(32'h44);
        tick();
        drive(32'h55);
        alu_overflow = 1'b1;
        ovf_trap_en  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ar_pre_exc", exc_ovf, 1);
        check("ar_pre_ready", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_exc", exc_ovf, 0);
        check("ar_redir", redirect_valid, 0);
        #1 rst_n = 1'b1;
        tick();
        check("ar_ready", in_ready, 1);
        check("ar_after_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
